// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle between the ID/EX stage and the ALU/mul/div execute unit.
// Handshake: an op is accepted on a rising edge where in_valid && in_ready && !flush;
// in_ready depends on unit state only, and out_valid is a one-cycle result pulse.
interface alu_muldiv_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [1:0]      ALUOp_in;
  logic [6:0]      func7;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic [4:0]      AluControl_out;

  modport master (
    output in_valid, flush, ALUOp_in, func7, func3, op_a, op_b,
    input  in_ready, out_valid, result, zero, illegal, AluControl_out
  );

  modport slave (
    input  in_valid, flush, ALUOp_in, func7, func3, op_a, op_b,
    output in_ready, out_valid, result, zero, illegal, AluControl_out
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// RV32I/RV64I ALU + M-extension execute unit: decodes ALUOp/func3/func7, computes
// one-cycle ops with a registered result and runs DIV/REM as a restoring divider.
module alu_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_muldiv_unit_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3,  OP_SLTU   = 5'd4,  OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6,  OP_SRA    = 5'd7,  OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM    = 5'd16, OP_REMU  = 5'd17;
  localparam logic [4:0] OP_ILL  = 5'h1F;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV_RUN = 2'd1, DIV_FIX = 2'd2} state_t;
  state_t state, state_next;

  logic [4:0]        code;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] prod;
  logic              ext_a, ext_b;
  logic              is_div, div_signed, want_rem, div_zero, div_ovf, start_div, accept;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   quo, rem_q, dvsr;
  logic [CW-1:0]     cnt;
  logic              neg_q, neg_r, sel_rem;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   q_fix, r_fix, div_res;
  logic [SW-1:0]     shamt;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    code = OP_ILL;
    case (bus.ALUOp_in)
      2'b00: code = OP_ADD;
      2'b01: code = OP_SUB;
      2'b10: begin
        if (bus.func7 == 7'b0000000) code = base_op(bus.func3);
        else if (bus.func7 == 7'b0100000 && bus.func3 == 3'b000) code = OP_SUB;
        else if (bus.func7 == 7'b0100000 && bus.func3 == 3'b101) code = OP_SRA;
        else if (bus.func7 == 7'b0000001) code = OP_MUL + {2'b00, bus.func3};
      end
      default: begin
        // Immediate forms ignore func7 except for the shift-immediate encodings.
        if (bus.func3 == 3'b001) begin
          if (bus.func7 == 7'b0000000) code = OP_SLL;
        end else if (bus.func3 == 3'b101) begin
          if (bus.func7 == 7'b0000000) code = OP_SRL;
          else if (bus.func7 == 7'b0100000) code = OP_SRA;
        end else begin
          code = base_op(bus.func3);
        end
      end
    endcase
  end

  assign shamt      = bus.op_b[SW-1:0];
  assign ext_a      = bus.op_a[XLEN-1] & ((code == OP_MULH) | (code == OP_MULHSU));
  assign ext_b      = bus.op_b[XLEN-1] & (code == OP_MULH);
  assign prod       = {{XLEN{ext_a}}, bus.op_a} * {{XLEN{ext_b}}, bus.op_b};
  assign is_div     = (code >= OP_DIV) && (code <= OP_REMU);
  assign div_signed = (code == OP_DIV) || (code == OP_REM);
  assign want_rem   = (code == OP_REM) || (code == OP_REMU);
  assign div_zero   = (bus.op_b == '0);
  assign div_ovf    = div_signed && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
  assign start_div  = is_div && !div_zero && !div_ovf;
  assign mag_a      = (div_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
  assign mag_b      = (div_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;

  always_comb begin
    fast_res = '0;
    case (code)
      OP_ADD:  fast_res = bus.op_a + bus.op_b;
      OP_SUB:  fast_res = bus.op_a - bus.op_b;
      OP_SLL:  fast_res = bus.op_a << shamt;
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      OP_XOR:  fast_res = bus.op_a ^ bus.op_b;
      OP_SRL:  fast_res = bus.op_a >> shamt;
      OP_SRA:  fast_res = $signed(bus.op_a) >>> shamt;
      OP_OR:   fast_res = bus.op_a | bus.op_b;
      OP_AND:  fast_res = bus.op_a & bus.op_b;
      OP_MUL:  fast_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fast_res = prod[2*XLEN-1:XLEN];
      // Only the zero-divisor and signed-overflow cases are resolved here.
      OP_DIV, OP_DIVU: fast_res = div_zero ? '1 : bus.op_a;
      OP_REM, OP_REMU: fast_res = div_zero ? bus.op_a : '0;
      default: fast_res = '0;
    endcase
  end

  assign shifted = {rem_q, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem_q : rem_q;
  assign div_res = sel_rem ? r_fix : q_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          accept = 1'b1;
          if (start_div) state_next = DIV_RUN;
        end
      end
      DIV_RUN: if (cnt == CW'(1)) state_next = DIV_FIX;
      DIV_FIX: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  assign bus.in_ready = (state == IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.result         <= '0;
      bus.zero           <= 1'b1;
      bus.illegal        <= 1'b0;
      bus.AluControl_out <= '0;
      quo     <= '0;
      rem_q   <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (accept) begin
        bus.AluControl_out <= code;
        bus.illegal        <= (code == OP_ILL);
        if (start_div) begin
          quo     <= mag_a;
          rem_q   <= '0;
          dvsr    <= mag_b;
          cnt     <= CW'(XLEN);
          neg_q   <= div_signed & (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
          neg_r   <= div_signed & bus.op_a[XLEN-1];
          sel_rem <= want_rem;
        end else begin
          bus.out_valid <= 1'b1;
          bus.result    <= fast_res;
          bus.zero      <= (fast_res == '0);
        end
      end else if (state == DIV_RUN && !bus.flush) begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!diff[XLEN]) begin
          rem_q <= diff[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= shifted[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
      end else if (state == DIV_FIX && !bus.flush) begin
        bus.out_valid <= 1'b1;
        bus.result    <= div_res;
        bus.zero      <= (div_res == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit: directed steps plus randomized ops checked against an
// arithmetic reference model through an expected-result queue.
module tb_alu_muldiv_unit;
  localparam int XLEN = 32;
  localparam int EW   = 44;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  alu_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  alu_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs {latency[5:0], illegal, opcode[4:0], result[31:0]}.
  function automatic logic [EW-1:0] model(input logic [1:0] aop, input logic [6:0] f7,
                                          input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int code, lat, ia, ib, sh;
    int base[8];
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [31:0] r;
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    sa = $signed(a); sb = $signed(b); ua = a; ub = b; ia = a; ib = b;
    sh = int'(b[4:0]);
    code = 31;
    case (aop)
      2'd0: code = 0;
      2'd1: code = 1;
      2'd2: begin
        if (f7 == 7'h00) code = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
        else if (f7 == 7'h01) code = 10 + int'(f3);
      end
      default: begin
        if (f3 == 3'd1) code = (f7 == 7'h00) ? 2 : 31;
        else if (f3 == 3'd5) code = (f7 == 7'h00) ? 6 : ((f7 == 7'h20) ? 7 : 31);
        else code = base[f3];
      end
    endcase
    r = '0;
    lat = 1;
    case (code)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << sh;
      3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4:  r = (ua < ub) ? 32'd1 : 32'd0;
      5:  r = a ^ b;
      6:  r = a >> sh;
      7:  begin p = sa >>> sh; r = p[31:0]; end
      8:  r = a | b;
      9:  r = a & b;
      10: begin p = sa * sb; r = p[31:0]; end
      11: begin p = sa * sb; r = p[63:32]; end
      12: begin p = sa * longint'(ub); r = p[63:32]; end
      13: begin pu = ua * ub; r = pu[63:32]; end
      14: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin r = ia / ib; lat = 34; end
      end
      15: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin r = a / b; lat = 34; end
      end
      16: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin r = ia % ib; lat = 34; end
      end
      17: begin
        if (b == 32'd0) r = a;
        else begin r = a % b; lat = 34; end
      end
      default: r = '0;
    endcase
    return {6'(lat), code == 31, 5'(code), r};
  endfunction

  task automatic drive(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.ALUOp_in = aop;
    bus.func7    = f7;
    bus.func3    = f3;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  task automatic send(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    if (expect_result) exp_q.push_back(model(aop, f7, f3, a, b));
    check("ready_before_issue", bus.in_ready, 1);
    drive(aop, f7, f3, a, b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    logic [EW-1:0] e;
    int lat, busy;
    lat = 1;
    busy = 0;
    while (!bus.out_valid && lat < 80) begin
      if (!bus.in_ready) busy++;
      tick();
      lat++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_latency"}, lat, e[43:38]);
    check({tag, "_busy"}, busy, e[43:38] - 6'd1);
    check({tag, "_result"}, bus.result, e[31:0]);
    check({tag, "_zero"}, bus.zero, e[31:0] == 32'd0);
    check({tag, "_illegal"}, bus.illegal, e[37]);
    check({tag, "_code"}, bus.AluControl_out, e[36:32]);
    tick();
    check({tag, "_pulse"}, bus.out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    send(aop, f7, f3, a, b, 1'b1);
    collect(tag);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [EW-1:0] e1, e2;
    int seen;
    logic [6:0] f7r;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.ALUOp_in = 2'b00;
    bus.func7    = 7'd0;
    bus.func3    = 3'd0;
    bus.op_a     = '0;
    bus.op_b     = '0;

    repeat (3) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_illegal", bus.illegal, 0);
    check("rst_code", bus.AluControl_out, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("idle_no_valid", bus.out_valid, 0);

    run_op("and", 2'b10, 7'h00, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and_const", bus.result, 32'h00F0_00F0);
    check("and_code9", bus.AluControl_out, 5'd9);

    // AND immediately followed by ADD: no stall between them.
    e1 = model(2'b10, 7'h00, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    e2 = model(2'b00, 7'h55, 3'b010, 32'h1234_5678, 32'h1111_1111);
    drive(2'b10, 7'h00, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    check("b2b_first_valid", bus.out_valid, 1);
    check("b2b_first_result", bus.result, e1[31:0]);
    check("b2b_ready", bus.in_ready, 1);
    drive(2'b00, 7'h55, 3'b010, 32'h1234_5678, 32'h1111_1111);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_second_valid", bus.out_valid, 1);
    check("b2b_second_result", bus.result, e2[31:0]);
    check("b2b_second_code", bus.AluControl_out, e2[36:32]);
    tick();

    run_op("srai", 2'b11, 7'h20, 3'b101, 32'h8000_0000, 32'd4);
    check("srai_const", bus.result, 32'hF800_0000);
    run_op("srai_bad", 2'b11, 7'h10, 3'b101, 32'h8000_0000, 32'd4);
    check("srai_bad_illegal", bus.illegal, 1);
    check("srai_bad_code", bus.AluControl_out, 5'h1F);
    run_op("mulh", 2'b10, 7'h01, 3'b001, 32'hFFFF_FFFF, 32'd2);
    check("mulh_const", bus.result, 32'hFFFF_FFFF);
    run_op("mulhu", 2'b10, 7'h01, 3'b011, 32'hFFFF_FFFF, 32'd2);
    check("mulhu_const", bus.result, 32'h0000_0001);
    run_op("div", 2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd2);
    check("div_const", bus.result, 32'hFFFF_FFFD);
    run_op("rem", 2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 32'd2);
    check("rem_const", bus.result, 32'hFFFF_FFFF);
    run_op("divu_by0", 2'b10, 7'h01, 3'b101, 32'h0000_1234, 32'd0);
    check("divu_by0_const", bus.result, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 7'h01, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", bus.result, 32'h8000_0000);
    run_op("rem_ovf", 2'b10, 7'h01, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf_zero", bus.zero, 1);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    f7r = 7'h00;
        2:       f7r = 7'h20;
        3, 4:    f7r = 7'h01;
        default: f7r = 7'($urandom);
      endcase
      run_op("rand", 2'($urandom_range(0, 3)), f7r, 3'($urandom_range(0, 7)),
             rand_operand(), rand_operand());
    end

    // Flush mid-divide: the result from the preceding ADD must survive.
    run_op("pre_flush_add", 2'b00, 7'h00, 3'b000, 32'd5, 32'd6);
    send(2'b10, 7'h01, 3'b100, 32'd100, 32'd7, 1'b0);
    repeat (9) tick();
    check("flush_busy", bus.in_ready, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_ready", bus.in_ready, 1);
    check("flush_no_valid", bus.out_valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("flush_never_valid", seen, 0);
    check("flush_hold_result", bus.result, 32'd11);
    check("flush_hold_zero", bus.zero, 0);

    // Flush wins over a simultaneous request.
    bus.flush = 1'b1;
    drive(2'b01, 7'h00, 3'b000, 32'd9, 32'd9);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_prio_valid", bus.out_valid, 0);
    check("flush_prio_code", bus.AluControl_out, 5'd14);
    check("flush_prio_ready", bus.in_ready, 1);
    tick();
    check("flush_prio_late_valid", bus.out_valid, 0);

    // Asynchronous reset mid-divide.
    send(2'b10, 7'h01, 3'b111, 32'd1000, 32'd3, 1'b0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_result", bus.result, 0);
    check("arst_zero", bus.zero, 1);
    check("arst_illegal", bus.illegal, 0);
    check("arst_code", bus.AluControl_out, 0);
    check("arst_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("arst_never_valid", seen, 0);
    run_op("post_rst_sub", 2'b01, 7'h00, 3'b000, 32'd3, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
